// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_ctrl
// Purpose  : Direct-mapped instruction cache controller. Lines hold 4 x 32-bit
//            words. Tag and data arrays are external single-port synchronous
//            RAMs with 1-cycle read latency. Misses refill the whole line
//            through a simple req/ack memory port, one word per ack.
// Ports    : clk, rst (async, active-low)
//            cpu_*   - CPU fetch request / single-cycle response strobe
//            flush_* - invalidate-all request and busy status
//            tag_*   - tag RAM port, entry = {valid, tag}
//            data_*  - data RAM port, address = {index, word}
//            mem_*   - refill port, address held until mem_ack_i
//            hit_cnt_o / miss_cnt_o - lookup statistics
// Config   : define ICACHE_STATS_EN to enable the hit/miss counters;
//            otherwise both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
   parameter int TAG_BITS   = 20,   // TAG_BITS + INDEX_BITS + 4 must equal 32
   parameter int INDEX_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_i,
   input  logic [31:0]           cpu_addr_i,
   output logic                  cpu_ready_o,
   output logic                  cpu_rvalid_o,
   output logic [31:0]           cpu_rdata_o,
   input  logic                  flush_i,
   output logic                  flush_busy_o,
   output logic [INDEX_BITS-1:0] tag_addr_o,
   output logic [TAG_BITS:0]     tag_wdata_o,
   output logic                  tag_we_o,
   input  logic [TAG_BITS:0]     tag_rdata_i,
   output logic [INDEX_BITS+1:0] data_addr_o,
   output logic [31:0]           data_wdata_o,
   output logic                  data_we_o,
   input  logic [31:0]           data_rdata_i,
   output logic                  mem_req_o,
   output logic [31:0]           mem_addr_o,
   input  logic                  mem_ack_i,
   input  logic [31:0]           mem_rdata_i,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      REFILL  = 3'd2,
      RESPOND = 3'd3,
      FLUSH   = 3'd4
   } state_t;

   state_t                state, state_nx;
   logic [31:2]           addr_q, addr_nx;        // byte offset is never needed
   logic [1:0]            cnt, cnt_nx;            // refill word counter
   logic [INDEX_BITS-1:0] flush_idx, flush_idx_nx;
   logic [31:0]           word_q, word_nx;        // requested word seen during refill

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_index;
   logic                  hit;
   logic                  unused_addr_lsbs;

   assign req_tag   = addr_q[31:32-TAG_BITS];
   assign req_index = addr_q[INDEX_BITS+3:4];
   assign hit       = tag_rdata_i[TAG_BITS] && (tag_rdata_i[TAG_BITS-1:0] == req_tag);

   // Fetches are word aligned; the byte offset is accepted but ignored.
   assign unused_addr_lsbs = ^cpu_addr_i[1:0];

   // Reset parks the FSM in FLUSH at index 0, so leaving reset always walks
   // the whole tag array before the first request can be accepted. A refill
   // interrupted by reset never wrote its tag, so no partial line survives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FLUSH;
         addr_q    <= '0;
         cnt       <= '0;
         flush_idx <= '0;
         word_q    <= '0;
      end else begin
         state     <= state_nx;
         addr_q    <= addr_nx;
         cnt       <= cnt_nx;
         flush_idx <= flush_idx_nx;
         word_q    <= word_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      addr_nx      = addr_q;
      cnt_nx       = cnt;
      flush_idx_nx = flush_idx;
      word_nx      = word_q;
      cpu_ready_o  = 1'b0;
      cpu_rvalid_o = 1'b0;
      cpu_rdata_o  = '0;
      flush_busy_o = 1'b0;
      tag_addr_o   = '0;
      tag_wdata_o  = '0;
      tag_we_o     = 1'b0;
      data_addr_o  = '0;
      data_wdata_o = '0;
      data_we_o    = 1'b0;
      mem_req_o    = 1'b0;
      mem_addr_o   = '0;

      case (state)
         IDLE: begin
            cpu_ready_o = !flush_i;
            // Both RAMs are addressed straight from the request so the tag
            // and the word are available in LOOKUP without an extra cycle.
            tag_addr_o  = cpu_addr_i[INDEX_BITS+3:4];
            data_addr_o = cpu_addr_i[INDEX_BITS+3:2];
            if (flush_i) begin
               state_nx     = FLUSH;
               flush_idx_nx = '0;
            end else if (cpu_req_i) begin
               addr_nx  = cpu_addr_i[31:2];
               state_nx = LOOKUP;
            end
         end

         LOOKUP: begin
            if (hit) begin
               cpu_rvalid_o = 1'b1;
               cpu_rdata_o  = data_rdata_i;
               state_nx     = IDLE;
            end else begin
               cnt_nx   = '0;
               state_nx = REFILL;
            end
         end

         REFILL: begin
            // Line is fetched from word 0 upward; the address only moves
            // when the memory acknowledges the current word.
            mem_req_o  = 1'b1;
            mem_addr_o = {addr_q[31:4], cnt, 2'b00};
            if (mem_ack_i) begin
               data_we_o    = 1'b1;
               data_addr_o  = {req_index, cnt};
               data_wdata_o = mem_rdata_i;
               cnt_nx       = cnt + 2'd1;
               if (cnt == addr_q[3:2]) begin
                  word_nx = mem_rdata_i;
               end
               // Tag goes valid only together with the last data word.
               if (cnt == 2'd3) begin
                  tag_we_o    = 1'b1;
                  tag_addr_o  = req_index;
                  tag_wdata_o = {1'b1, req_tag};
                  state_nx    = RESPOND;
               end
            end
         end

         RESPOND: begin
            cpu_rvalid_o = 1'b1;
            cpu_rdata_o  = word_q;
            state_nx     = IDLE;
         end

         FLUSH: begin
            flush_busy_o = 1'b1;
            tag_we_o     = 1'b1;
            tag_addr_o   = flush_idx;
            flush_idx_nx = flush_idx + INDEX_BITS'(1);
            if (&flush_idx) begin
               state_nx = IDLE;
            end
         end

         default: state_nx = FLUSH;
      endcase
   end

`ifdef ICACHE_STATS_EN
   logic        lookup_hit;
   logic        lookup_miss;
   logic        flush_entry;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   assign lookup_hit  = (state == LOOKUP) && hit;
   assign lookup_miss = (state == LOOKUP) && !hit;
   assign flush_entry = (state == IDLE) && flush_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (flush_entry) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (lookup_hit) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (lookup_miss) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt;
   assign miss_cnt_o = miss_cnt;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter TAG_BITS, default 20, tag field width; TAG_BITS+INDEX_BITS+4 SHALL equal 32.
REQ-002 Parameter INDEX_BITS, default 8, set index width (2**INDEX_BITS sets, direct-mapped, 4 x 32-bit words per line).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_req_i  input  1 / cpu_addr_i  input  32 / cpu_ready_o  output  1: request accepted when cpu_req_i && cpu_ready_o.
REQ-006 cpu_rvalid_o  output  1 / cpu_rdata_o  output  32: single-cycle response strobe and fetched word.
REQ-007 flush_i  input  1 / flush_busy_o  output  1: invalidate-all request and status.
REQ-008 tag_addr_o  output  INDEX_BITS / tag_wdata_o  output  TAG_BITS+1 ({valid,tag}) / tag_we_o  output  1 / tag_rdata_i  input  TAG_BITS+1: tag RAM port, 1-cycle read latency.
REQ-009 data_addr_o  output  INDEX_BITS+2 / data_wdata_o  output  32 / data_we_o  output  1 / data_rdata_i  input  32: data RAM port, 1-cycle read latency.
REQ-010 mem_req_o  output  1 / mem_addr_o  output  32 / mem_ack_i  input  1 / mem_rdata_i  input  32: refill port.

Function
REQ-011 States SHALL be IDLE, LOOKUP, REFILL, RESPOND, FLUSH.
REQ-012 cpu_ready_o SHALL be 1 only in IDLE with flush_i low.
REQ-013 IDLE: flush_i high -> FLUSH (priority over cpu_req_i); else accepted request latches address, drives tag_addr_o=addr[INDEX+3:4], data_addr_o=addr[INDEX+3:2] -> LOOKUP.
REQ-014 LOOKUP: hit = tag_rdata_i[TAG_BITS] && tag_rdata_i[TAG_BITS-1:0]==addr[31:32-TAG_BITS]; hit -> cpu_rvalid_o=1, cpu_rdata_o=data_rdata_i, -> IDLE (hit latency 2 cycles from acceptance).
REQ-015 LOOKUP miss -> REFILL, word counter = 0.
REQ-016 REFILL: mem_req_o=1, mem_addr_o={addr[31:4],cnt,2'b00}, held stable until mem_ack_i; on ack: data_we_o=1, data_addr_o={index,cnt}, data_wdata_o=mem_rdata_i, cnt increments.
REQ-017 Word with cnt==addr[3:2] SHALL be captured for the response.
REQ-018 On 4th ack: tag_we_o=1, tag_wdata_o={1'b1,tag} -> RESPOND; mem_req_o SHALL deassert the cycle after the 4th ack.
REQ-019 RESPOND: cpu_rvalid_o=1 with captured word for one cycle -> IDLE (miss latency = 4 acks + 3 cycles).
REQ-020 flush_i during LOOKUP/REFILL/RESPOND SHALL NOT abort; it is honoured on return to IDLE if still high.
REQ-021 FLUSH: flush_busy_o=1; walks index 0..2**INDEX_BITS-1, one per cycle, tag_we_o=1, tag_wdata_o=0; after last index -> IDLE.
REQ-022 mem_ack_i outside REFILL SHALL be ignored.

Reset
REQ-023 rst low SHALL immediately force state FLUSH, index 0, cnt 0, and all outputs to 0 except the FLUSH-state outputs.
REQ-024 Upon rst release the FSM SHALL complete a full flush (2**INDEX_BITS cycles) before first cpu_ready_o.
REQ-025 Reset mid-REFILL SHALL drop the refill; no partial line becomes valid.

Configuration
REQ-026 Macro ICACHE_STATS_EN defined: 32-bit outputs hit_cnt_o and miss_cnt_o increment on each LOOKUP hit/miss, wrap at 2**32, clear on reset and on FLUSH entry.
REQ-027 Macro undefined: hit_cnt_o and miss_cnt_o SHALL exist and be tied to 0.

Verification
REQ-028 Reset release -> cpu_ready_o low exactly 256 cycles, tag_we_o high with tag_wdata_o=0 each cycle, then ready=1.
REQ-029 Read 0x0000_1008 cold -> miss, mem_addr_o 0x1000,0x1004,0x1008,0x100C, rvalid with word from 0x1008; repeat read -> hit, rvalid 2 cycles after acceptance.
REQ-030 Read 0x0000_1008 then 0x0010_1008 (same index, different tag) -> second misses, refills, tag 0x00101 written.
REQ-031 mem_ack_i delayed 5 cycles per word -> mem_addr_o stable, rvalid only after 4th ack.
REQ-032 flush_i asserted during REFILL -> refill completes, response returned, then FLUSH; subsequent read of same line misses.
REQ-033 rst low after 2nd ack -> FSM in FLUSH, mem_req_o low; after flush, read of that line misses (ICACHE_STATS_EN: miss_cnt_o=1).
